// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and the saturated quotient constant.
package seq_div_pkg;

  localparam int unsigned DefaultDw = 16;

  // Quotient reported for divide-by-zero and overflow results.
  localparam logic [DefaultDw-1:0] QuotAllOnes = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare against the
// divisor and conditionally subtract.
module div_step #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);

  logic [DW:0] r_ext;

  always_comb begin
    r_ext = {rem_i, bit_i};
    q_o   = (r_ext >= {1'b0, divisor_i});
    // rem_i < divisor guarantees the result fits in DW bits, so the low DW
    // bits of the subtraction are the whole answer.
    rem_o = q_o ? (r_ext[DW-1:0] - divisor_i) : r_ext[DW-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned 2*DW / DW divider, one quotient bit per clock, with
// divide-by-zero and quotient-overflow detection up front.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned DW = DefaultDw
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero,
  output logic            ovf
);

  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] QuotOnes = {DW{QuotAllOnes[0]}};

  state_e          state_q, state_d;
  logic [DW-1:0]   dlo_q, dlo_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   quot_q, quot_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;

  logic [DW-1:0]   step_rem;
  logic            step_q;

  div_step #(
    .DW(DW)
  ) u_div_step (
    .rem_i    (rem_q),
    .bit_i    (dlo_q[cnt_q]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  always_comb begin
    state_d    = state_q;
    dlo_d      = dlo_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dlo_d      = dividend[DW-1:0];
          divisor_d  = divisor;
          quot_d     = '0;
          rem_d      = '0;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
          if (divisor == '0) begin
            div_zero_d = 1'b1;
            quot_d     = QuotOnes;
            rem_d      = dividend[DW-1:0];
            state_d    = StDone;
          end else if (dividend[2*DW-1:DW] >= divisor) begin
            // Upper half already >= divisor: quotient would need DW+1 bits.
            ovf_d   = 1'b1;
            quot_d  = QuotOnes;
            state_d = StDone;
          end else begin
            rem_d   = dividend[2*DW-1:DW];
            cnt_d   = CntW'(DW - 1);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        rem_d  = step_rem;
        quot_d = {quot_q[DW-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      dlo_q      <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dlo_q      <= dlo_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter DW, default 16, giving the divisor/quotient/remainder width; dividend width is 2*DW.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  2*DW  numerator, unsigned; sampled on the accepting edge.
REQ-006 SHALL have port divisor  input  DW  denominator, unsigned; sampled on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port quotient  output  DW  result quotient.
REQ-010 SHALL have port remainder  output  DW  result remainder.
REQ-011 SHALL have port div_zero  output  1  divisor was zero; valid with done.
REQ-012 SHALL have port ovf  output  1  quotient does not fit in DW bits; valid with done.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, SHALL capture dividend and divisor, clear quotient, remainder and flags, and classify the operands.
- divisor==0: set div_zero, go to DONE.
- else dividend[2*DW-1:DW] >= divisor: set ovf, go to DONE.
- else: load partial remainder = dividend[2*DW-1:DW], step counter = DW-1, go to RUN.
REQ-015 SHALL perform one restoring step per RUN cycle, MSB first, for i = DW-1 down to 0.
- Form r' = {partial remainder, dividend[i]} at DW+1 bits.
- If r' >= divisor: partial remainder = r' - divisor and quotient bit i = 1.
- Else: partial remainder = r' and quotient bit i = 0.
REQ-016 SHALL leave RUN for DONE on the edge that completes step i=0, so exactly DW RUN edges occur.
REQ-017 SHALL assert done only in DONE, return to IDLE on the next edge, and keep done high for exactly one cycle.
REQ-018 Normal-case latency SHALL be DW+1 edges from the accepting edge to done; error-case latency SHALL be 1 edge.
REQ-019 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; there is no queuing and a back-to-back start must wait for IDLE.
REQ-021 Operand changes after the accepting edge SHALL have no effect on the result.
REQ-022 On a div_zero result: quotient = all ones, remainder = dividend[DW-1:0], ovf = 0.
REQ-023 On an ovf result: quotient = all ones, remainder = 0.
REQ-024 quotient, remainder, div_zero and ovf SHALL hold their values from done until the next accepting edge.
REQ-025 For a valid result, dividend SHALL equal quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, ovf=0, counter=0, regardless of clk.
REQ-027 Reset during RUN SHALL abandon the operation with no done pulse; the first edge after reset release may accept start.

Structure
REQ-028 A shared package SHALL hold the default DW, the FSM state enumeration, and the all-ones quotient constant; a multiplier can use the same width constant.
REQ-029 SHALL instantiate exactly one sub-module, div_step: combinational, DW+1-bit compare/subtract, outputs next remainder and quotient bit.

Verification
REQ-030 Start with dividend=100, divisor=7 -> done 17 cycles after start, quotient=14, remainder=2, flags 0.
REQ-031 Start with dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0; then 0x0001ABCD / 0x0010 -> quotient=0x1ABC, remainder=0xD.
REQ-032 Start with dividend=0x12345678, divisor=0 -> done after 1 cycle, div_zero=1, quotient=0xFFFF, remainder=0x5678.
REQ-033 Start with dividend=0x00010000, divisor=1 -> done after 1 cycle, ovf=1, quotient=0xFFFF, remainder=0.
REQ-034 Pulse start with new operands on RUN cycle 5 -> ignored, first result unchanged; retry after the done cycle is accepted.
REQ-035 Assert rst during RUN cycle 8 -> busy=0 and all outputs 0 without waiting for a clock edge, no done pulse; a fresh 100/7 then gives 14 r 2.
